// File: rtl/kernel_mac.sv
// kernel_mac: streaming TAPS-point signed multiply-accumulate for the 5x5
// convolution stage. It loads a kernel once over the weight port, then
// produces one saturated dot product per pixel window.
// Optional feature macro: KERNEL_MAC_RELU_EN clamps negative results to zero.
module kernel_mac #(
    parameter int TAPS   = 25,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_w,
    input  logic                     w_valid,
    input  logic signed [DATA_W-1:0] w_data,
    output logic                     w_ready,
    input  logic                     px_valid,
    input  logic signed [DATA_W-1:0] px_data,
    output logic                     px_ready,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  out_data,
    input  logic                     out_ready,
    output logic                     loaded
);

    localparam int              IDX_W    = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                    r_state;
    logic [IDX_W-1:0]          r_idx;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_loaded;
    logic                      r_out_valid;
    logic signed [OUT_W-1:0]   r_out_data;
    logic signed [DATA_W-1:0]  r_w [TAPS];

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic signed [OUT_W-1:0]    w_result;

    // Clamp the wide sum into OUT_W: the sum fits only when every bit above
    // the output sign bit matches that sign bit.
    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-OUT_W:0]    hi;
        logic signed [OUT_W-1:0] res;
        hi = v[ACC_W-1:OUT_W-1];
        if ((hi == '0) || (hi == '1)) begin
            res = v[OUT_W-1:0];
        end else if (v[ACC_W-1]) begin
            res = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            res = {1'b0, {(OUT_W-1){1'b1}}};
        end
`ifdef KERNEL_MAC_RELU_EN
        if (res[OUT_W-1]) begin
            res = '0;
        end
`else
`endif
        return res;
    endfunction

    // Full-precision product of the current pixel and its matching weight,
    // sign-extended into the accumulator width.
    assign w_prod     = px_data * r_w[r_idx];
    assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    assign w_acc_next = r_acc + w_prod_ext;
    assign w_result   = sat_out(w_acc_next);

    // Handshake readies decode registered state only, so no input reaches them.
    assign w_ready   = (r_state == LOAD);
    assign px_ready  = (r_state == RUN);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign loaded    = r_loaded;

    // Weight store: written only while loading; contents are not reset
    // because a fresh load always rewrites every entry before use.
    always_ff @(posedge clk) begin
        if ((r_state == LOAD) && w_valid) begin
            r_w[r_idx] <= w_data;
        end
    end

    // Control FSM and accumulator: load weights, accumulate a window, hold
    // the result until downstream takes it. clear_w outranks everything
    // except reset, and leaves the last result register untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= LOAD;
            r_idx       <= '0;
            r_acc       <= '0;
            r_loaded    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (clear_w) begin
            r_state     <= LOAD;
            r_idx       <= '0;
            r_acc       <= '0;
            r_loaded    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_valid) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx    <= '0;
                            r_acc    <= '0;
                            r_loaded <= 1'b1;
                            r_state  <= RUN;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (px_valid) begin
                        if (r_idx == LAST_IDX) begin
                            r_out_data  <= w_result;
                            r_out_valid <= 1'b1;
                            r_idx       <= '0;
                            r_acc       <= '0;
                            r_state     <= OUT;
                        end else begin
                            r_acc <= w_acc_next;
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= RUN;
                    end
                end
                default: begin
                    r_state     <= LOAD;
                    r_idx       <= '0;
                    r_acc       <= '0;
                    r_loaded    <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_mac.sv
// Self-checking bench for kernel_mac: directed scenarios plus randomized
// windows compared against a plain-arithmetic dot-product model.
module tb_kernel_mac;

    localparam int TAPS = 25;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                clear_w = 1'b0;
    logic                w_valid = 1'b0;
    logic signed [15:0]  w_data = '0;
    logic                w_ready;
    logic                px_valid = 1'b0;
    logic signed [15:0]  px_data = '0;
    logic                px_ready;
    logic                out_valid;
    logic signed [31:0]  out_data;
    logic                out_ready = 1'b0;
    logic                loaded;

    int checks = 0;
    int errors = 0;

    logic signed [15:0] wts [TAPS];
    logic signed [15:0] pix [TAPS];

    kernel_mac #(.TAPS(TAPS), .DATA_W(16), .ACC_W(40), .OUT_W(32)) dut (
        .clk(clk), .reset(reset), .clear_w(clear_w),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .loaded(loaded)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact dot product, then clamp to 32-bit signed range.
    function automatic logic signed [31:0] model_out();
        longint s;
        s = 0;
        for (int i = 0; i < TAPS; i++) s += longint'(wts[i]) * longint'(pix[i]);
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        else if (s < -64'sd2147483648) s = -64'sd2147483648;
`ifdef KERNEL_MAC_RELU_EN
        if (s < 0) s = 0;
`else
`endif
        return s[31:0];
    endfunction

    task automatic pulse_clear();
        clear_w = 1'b1;
        tick();
        clear_w = 1'b0;
    endtask

    task automatic send_weights(input bit gaps);
        for (int i = 0; i < TAPS; i++) begin
            int guard;
            guard = 0;
            if (gaps) begin
                w_valid = 1'b0;
                while ($urandom_range(0, 2) == 0) tick();
            end
            w_valid = 1'b1;
            w_data  = wts[i];
            while (!w_ready && guard < 50) begin
                tick();
                guard++;
            end
            if (!w_ready) begin
                checks++;
                errors++;
                $display("FAIL weight_handshake w_ready=%0b expected 1 (weight %0d)", w_ready, i);
            end
            tick();
        end
        w_valid = 1'b0;
    endtask

    task automatic send_pixels(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int guard;
            guard = 0;
            if (gaps) begin
                px_valid = 1'b0;
                while ($urandom_range(0, 2) == 0) tick();
            end
            px_valid = 1'b1;
            px_data  = pix[i];
            while (!px_ready && guard < 50) begin
                tick();
                guard++;
            end
            if (!px_ready) begin
                checks++;
                errors++;
                $display("FAIL pixel_handshake px_ready=%0b expected 1 (pixel %0d)", px_ready, i);
            end
            tick();
        end
        px_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (w_ready !== 1'b1 || px_ready !== 1'b0 || out_valid !== 1'b0 ||
            out_data !== 32'sd0 || loaded !== 1'b0) begin
            errors++;
            $display("FAIL reset_state w_ready=%0b px_ready=%0b out_valid=%0b out_data=%0d loaded=%0b expected 1 0 0 0 0",
                     w_ready, px_ready, out_valid, out_data, loaded);
        end
    endtask

    task automatic test_ones();
        for (int i = 0; i < TAPS; i++) begin
            wts[i] = 16'sd1;
            pix[i] = 16'(i + 1);
        end
        send_weights(1'b0);
        checks++;
        if (loaded !== 1'b1 || px_ready !== 1'b1) begin
            errors++;
            $display("FAIL ones_loaded loaded=%0b px_ready=%0b expected 1 1", loaded, px_ready);
        end
        out_ready = 1'b1;
        send_pixels(TAPS, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'sd325 || loaded !== 1'b1) begin
            errors++;
            $display("FAIL ones_result out_valid=%0b out_data=%0d loaded=%0b expected 1 325 1",
                     out_valid, out_data, loaded);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || px_ready !== 1'b1) begin
            errors++;
            $display("FAIL ones_release out_valid=%0b px_ready=%0b expected 0 1", out_valid, px_ready);
        end
    endtask

    // Reload a fixed kernel, run one window, compare with the given value.
    task automatic test_directed(input logic signed [15:0] wa, input logic signed [15:0] wb,
                                 input logic signed [15:0] p, input logic signed [31:0] expv);
        pulse_clear();
        for (int i = 0; i < TAPS; i++) begin
            wts[i] = (i % 2 == 0) ? wa : wb;
            pix[i] = p;
        end
        send_weights(1'b1);
        send_pixels(TAPS, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== expv || out_data !== model_out()) begin
            errors++;
            $display("FAIL directed_result w=%0d/%0d p=%0d out_valid=%0b out_data=%0d expected 1 %0d",
                     wa, wb, p, out_valid, out_data, expv);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic signed [31:0] exp1;
        logic signed [15:0] pix2 [TAPS];
        pulse_clear();
        for (int i = 0; i < TAPS; i++) begin
            wts[i]  = 16'($urandom_range(0, 400)) - 16'sd200;
            pix[i]  = 16'($urandom_range(0, 400)) - 16'sd200;
            pix2[i] = 16'($urandom_range(0, 400)) - 16'sd200;
        end
        send_weights(1'b0);
        send_pixels(TAPS, 1'b0);
        exp1 = model_out();
        px_valid = 1'b1;
        px_data  = pix2[0];
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp1 || px_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cycle=%0d out_valid=%0b out_data=%0d px_ready=%0b expected 1 %0d 0",
                         c, out_valid, out_data, px_ready, exp1);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (px_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready px_ready=%0b out_valid=%0b expected 1 0", px_ready, out_valid);
        end
        for (int i = 0; i < TAPS; i++) pix[i] = pix2[i];
        send_pixels(TAPS, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== model_out()) begin
            errors++;
            $display("FAIL b2b_second out_valid=%0b out_data=%0d expected 1 %0d",
                     out_valid, out_data, model_out());
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_clear();
        for (int i = 0; i < TAPS; i++) begin
            wts[i] = 16'sd1;
            pix[i] = 16'sd7;
        end
        pulse_clear();
        send_weights(1'b0);
        send_pixels(10, 1'b0);
        px_valid = 1'b1;
        clear_w  = 1'b1;
        tick();
        clear_w  = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || loaded !== 1'b0 || w_ready !== 1'b1 || px_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_state out_valid=%0b loaded=%0b w_ready=%0b px_ready=%0b expected 0 0 1 0",
                     out_valid, loaded, w_ready, px_ready);
        end
        px_valid = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            wts[i] = 16'sd2;
            pix[i] = 16'sd1;
        end
        send_weights(1'b0);
        send_pixels(TAPS, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'sd50) begin
            errors++;
            $display("FAIL clear_reload out_valid=%0b out_data=%0d expected 1 50", out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midout();
        for (int i = 0; i < TAPS; i++) begin
            wts[i] = 16'sd3;
            pix[i] = 16'sd5;
        end
        pulse_clear();
        send_weights(1'b0);
        send_pixels(TAPS, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'sd0 || w_ready !== 1'b1 || loaded !== 1'b0) begin
            errors++;
            $display("FAIL reset_midout out_valid=%0b out_data=%0d w_ready=%0b loaded=%0b expected 0 0 1 0",
                     out_valid, out_data, w_ready, loaded);
        end
        px_valid = 1'b1;
        px_data  = 16'sd1000;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (px_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_px_ignored px_ready=%0b expected 0", px_ready);
            end
            tick();
        end
        send_weights(1'b0);
        for (int i = 0; i < TAPS; i++) pix[i] = 16'(i - 12);
        send_pixels(TAPS, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== model_out()) begin
            errors++;
            $display("FAIL reset_reload out_valid=%0b out_data=%0d expected 1 %0d",
                     out_valid, out_data, model_out());
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int w = 0; w < 8; w++) begin
            int stall;
            logic signed [31:0] expv;
            if (w % 2 == 0) begin
                pulse_clear();
                for (int i = 0; i < TAPS; i++)
                    wts[i] = (w % 4 == 0) ? 16'($urandom) : 16'($urandom_range(0, 600)) - 16'sd300;
                send_weights(1'b1);
            end
            for (int i = 0; i < TAPS; i++)
                pix[i] = (w % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 600)) - 16'sd300;
            send_pixels(TAPS, 1'b1);
            expv  = model_out();
            stall = $urandom_range(0, 3);
            for (int c = 0; c <= stall; c++) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== expv) begin
                    errors++;
                    $display("FAIL random_result win=%0d cycle=%0d out_valid=%0b out_data=%0d expected 1 %0d",
                             w, c, out_valid, out_data, expv);
                end
                if (c < stall) tick();
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_directed(16'sd2, -16'sd3, 16'sd100,
`ifdef KERNEL_MAC_RELU_EN
                      32'sd0);
`else
                      -32'sd1000);
`endif
        test_directed(16'sd32767, 16'sd32767, 16'sd32767, 32'sd2147483647);
        test_directed(-16'sd32768, -16'sd32768, 16'sd32767,
`ifdef KERNEL_MAC_RELU_EN
                      32'sd0);
`else
                      -32'sd2147483648);
`endif
        test_back_to_back();
        test_clear();
        test_reset_midout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
